// File: rtl/alu4_pkg.sv
// Shared opcode constants and FSM state encoding for the accumulator stage.
package alu4_pkg;

   localparam logic [1:0] OP_ADD  = 2'b00;
   localparam logic [1:0] OP_SUB  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_MAX  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/addsub4.sv
// Combinational ripple-carry add/subtract. Subtraction inverts b and injects
// a carry-in of 1; signed overflow is the carry into the MSB xor carry out.
module addsub4 #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] bx;

   // Ripple chain, LSB to MSB.
   always_comb begin
      bx   = b ^ {WIDTH{sub}};
      c    = '0;
      sum  = '0;
      c[0] = sub;
      for (int i = 0; i < WIDTH; i++) begin
         sum[i]  = a[i] ^ bx[i] ^ c[i];
         c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
      end
   end

   assign cout = c[WIDTH];
   assign ovf  = c[WIDTH-1] ^ c[WIDTH];

endmodule

// File: rtl/alu4_accumulator.sv
// Accumulator sequencing stage: accepts one operand/opcode, applies it to the
// running accumulator in a single EXEC cycle, then holds the result until the
// consumer takes it.
module alu4_accumulator
   import alu4_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_acc,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0] as_sum;
   logic             as_ovf;
   logic             cout_unused;
   logic [CNT_W-1:0] cnt_inc;

   // SUB and MAX both need acc - data; only ADD adds.
   addsub4 #(
      .WIDTH (WIDTH)
   ) u_addsub4 (
      .a    (acc_q),
      .b    (data_q),
      .sub  (op_q != OP_ADD),
      .sum  (as_sum),
      .cout (cout_unused),
      .ovf  (as_ovf)
   );

   assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      op_d    = op_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               op_d    = in_op;
               state_d = EXEC;
            end
         end
         EXEC: begin
            state_d = RESP;
            unique case (op_q)
               OP_ADD, OP_SUB: begin
                  acc_d = as_sum;
                  ovf_d = ovf_q | as_ovf;
                  cnt_d = cnt_inc;
               end
               OP_LOAD: begin
                  acc_d = data_q;
                  ovf_d = 1'b0;
                  cnt_d = '0;
               end
               default: begin
                  // acc < data exactly when the true sign of acc - data is negative.
                  if (as_sum[WIDTH-1] ^ as_ovf) begin
                     acc_d = data_q;
                  end
                  cnt_d = cnt_inc;
               end
            endcase
         end
         RESP: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset; reset drops any pending op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         op_q    <= OP_ADD;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake flags decode directly from state; result ports mirror registers.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == RESP);
      out_acc   = acc_q;
      out_ovf   = ovf_q;
      out_count = cnt_q;
   end

endmodule

// File: tb/tb_alu4_accumulator.sv
// Scoreboard bench for alu4_accumulator: the driver pushes hand-computed
// expectations on accept, the monitor checks each presented result.
module tb_alu4_accumulator;

   localparam logic [1:0] ADD  = 2'b00;
   localparam logic [1:0] SUB  = 2'b01;
   localparam logic [1:0] LOAD = 2'b10;
   localparam logic [1:0] MAX  = 2'b11;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [1:0] in_op;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_acc;
   logic       out_ovf;
   logic [3:0] out_count;

   typedef struct {
      logic [3:0] acc;
      logic       ovf;
      logic [3:0] cnt;
      int         acc_cyc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   alu4_accumulator #(
      .WIDTH (4),
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_acc   (out_acc),
      .out_ovf   (out_ovf),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: compares on the first cycle of each response, then checks that
   // the response holds steady with in_ready low until the consumer takes it.
   logic       seen = 1'b0;
   logic       ready_chk = 1'b0;
   logic [3:0] snap_acc, snap_cnt;
   logic       snap_ovf;

   always @(negedge clk) begin
      if (rst) begin
         seen      = 1'b0;
         ready_chk = 1'b0;
      end else begin
         if (ready_chk) begin
            chk("in_ready_after_handshake", int'(in_ready), 1);
            chk("out_valid_after_handshake", int'(out_valid), 0);
            ready_chk = 1'b0;
         end
         if (out_valid) begin
            if (!seen) begin
               chk("response_expected", int'(q.size() > 0), 1);
               if (q.size() > 0) begin
                  // Accept edge N -> out_valid visible after edge N+1 (cycle N+2).
                  chk("latency", cyc - q[0].acc_cyc, 1);
                  chk("out_acc", int'(out_acc), int'(q[0].acc));
                  chk("out_ovf", int'(out_ovf), int'(q[0].ovf));
                  chk("out_count", int'(out_count), int'(q[0].cnt));
               end
               snap_acc = out_acc;
               snap_ovf = out_ovf;
               snap_cnt = out_count;
               seen     = 1'b1;
            end else begin
               chk("hold_acc", int'(out_acc), int'(snap_acc));
               chk("hold_ovf", int'(out_ovf), int'(snap_ovf));
               chk("hold_count", int'(out_count), int'(snap_cnt));
            end
            chk("in_ready_in_resp", int'(in_ready), 0);
            if (out_ready) begin
               if (q.size() > 0) void'(q.pop_front());
               seen      = 1'b0;
               ready_chk = 1'b1;
            end
         end
      end
   end

   // Drive one op; called at posedge+1. Returns the cycle count after the
   // accept edge, or -1 if in_ready never rose.
   task automatic issue(input logic [1:0] op, input logic [3:0] data, output int acc_cyc);
      int g = 0;
      in_op    = op;
      in_data  = data;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready || g >= 30) break;
         g++;
      end
      if (!in_ready) begin
         chk("in_ready_before_accept", int'(in_ready), 1);
         in_valid = 1'b0;
         acc_cyc  = -1;
      end else begin
         @(posedge clk);
         #1;
         acc_cyc = cyc;
      end
   endtask

   task automatic wait_drain();
      int g = 0;
      while (q.size() != 0 && g < 40) begin
         @(posedge clk);
         #1;
         g++;
      end
      if (q.size() != 0) begin
         chk("response_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   // hold > 0: keep out_ready low that many extra cycles and present a junk
   // op on in_valid throughout RESP, including the handshake cycle.
   task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [3:0] eacc,
                       input logic eovf, input logic [3:0] ecnt, input int hold);
      int   ac;
      exp_t e;
      issue(op, data, ac);
      if (ac >= 0) begin
         e.acc     = eacc;
         e.ovf     = eovf;
         e.cnt     = ecnt;
         e.acc_cyc = ac;
         q.push_back(e);
      end
      if (hold == 0) begin
         in_valid = 1'b0;
      end else begin
         in_op     = LOAD;
         in_data   = ~data;
         out_ready = 1'b0;
         repeat (2 + hold) @(posedge clk);
         #1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      wait_drain();
   endtask

   initial begin
      int ac;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_op     = ADD;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_out_acc", int'(out_acc), 0);
      chk("reset_out_ovf", int'(out_ovf), 0);
      chk("reset_out_count", int'(out_count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic arithmetic and sticky overflow.
      send(LOAD, 4'd3,  4'd3,  1'b0, 4'd0, 0);
      send(ADD,  4'd4,  4'd7,  1'b0, 4'd1, 0);
      send(ADD,  4'd1,  4'h8,  1'b1, 4'd2, 0);
      send(SUB,  4'd1,  4'd7,  1'b1, 4'd3, 0);
      send(LOAD, 4'd5,  4'd5,  1'b0, 4'd0, 0);
      send(ADD,  4'hE,  4'd3,  1'b0, 4'd1, 0);

      // Signed max.
      send(LOAD, 4'hD,  4'hD,  1'b0, 4'd0, 0);
      send(MAX,  4'd2,  4'd2,  1'b0, 4'd1, 0);
      send(LOAD, 4'd5,  4'd5,  1'b0, 4'd0, 0);
      send(MAX,  4'hA,  4'd5,  1'b0, 4'd1, 0);
      send(LOAD, 4'h8,  4'h8,  1'b0, 4'd0, 0);
      send(MAX,  4'd7,  4'd7,  1'b0, 4'd1, 0);

      // Backpressure with a junk op offered during RESP.
      send(SUB,  4'd2,  4'd5,  1'b0, 4'd2, 5);

      // Reset while the op sits in EXEC.
      issue(LOAD, 4'd6, ac);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midreset_in_ready", int'(in_ready), 1);
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_out_acc", int'(out_acc), 0);
      chk("midreset_out_ovf", int'(out_ovf), 0);
      chk("midreset_out_count", int'(out_count), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(LOAD, 4'd2,  4'd2,  1'b0, 4'd0, 0);

      // Counter saturation.
      send(LOAD, 4'd0,  4'd0,  1'b0, 4'd0, 0);
      for (int i = 1; i <= 17; i++) begin
         send(ADD, 4'd0, 4'd0, 1'b0, (i > 15) ? 4'd15 : 4'(i), 0);
      end

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("final_out_valid", int'(out_valid), 0);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Hard bound on total runtime.
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
